// File: rtl/ram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_if
// Bundles the two buses of the RAM stream reader:
//   - RAM initiator port : ram_oe, ram_wr, ram_addr, ram_din (to RAM),
//                          ram_dout (from RAM, valid one cycle after a read)
//   - output stream      : m_valid, m_data, m_last (to sink), m_ready (from sink)
// Modports:
//   master - the reader engine (drives the RAM port and the stream)
//   slave  - the environment (RAM plus stream sink)
// ---------------------------------------------------------------------------
interface ram_stream_reader_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          ram_oe;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  modport master (
    output ram_oe, ram_wr, ram_addr, ram_din, m_valid, m_data, m_last,
    input  ram_dout, m_ready
  );

  modport slave (
    input  ram_oe, ram_wr, ram_addr, ram_din, m_valid, m_data, m_last,
    output ram_dout, m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
// On start, reads len consecutive words from base_addr out of a single-port
// RAM (one-cycle read latency) and streams them out through a 2-entry FIFO
// so that sink backpressure never drops a word.
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset (aborts any transfer)
//   start      one-cycle request, accepted only while idle
//   base_addr  first RAM address (captured on accept)
//   len        word count 0..2^AW (captured on accept)
//   busy       high while a transfer is in progress
//   done       one-cycle pulse after the last word has been transferred
//   bus        RAM initiator port and output stream (master modport)
// ---------------------------------------------------------------------------
module ram_stream_reader #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int LW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [LW-1:0]        len,
  output logic                 busy,
  output logic                 done,
  ram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] issue_cnt_q, issue_cnt_d;
  logic [AW-1:0] ram_addr_q;

  // A read issued on one edge returns its word for capture on the next edge.
  logic          inflight_q;
  logic          inflight_last_q;

  // 2-entry output FIFO
  logic [DW-1:0] buf_data_q [2];
  logic          buf_last_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    buf_count_q;

  logic          push, pop, issue, issue_last;
  logic [2:0]    occupancy;

  assign push = inflight_q;
  assign pop  = (buf_count_q != 2'd0) && bus.m_ready;

  // Slots committed for the next cycle. A word leaving this cycle frees its
  // slot in time for a new read, which is what sustains one word per cycle;
  // occupancy can never exceed 2, so no word is ever dropped.
  assign occupancy  = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == S_READ) && (issue_cnt_q != '0) && (occupancy < 3'd2);
  assign issue_last = (issue_cnt_q == LW'(1));

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          issue_cnt_d = len;
          state_d     = (len == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + AW'(1);   // wraps modulo 2^AW
          issue_cnt_d = issue_cnt_q - LW'(1);
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (buf_count_q == 2'd0)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      issue_cnt_q     <= '0;
      ram_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (issue) ram_addr_q <= addr_q;
    end
  end

  // NOTE: the two FIFO data entries are reset as well, because m_data is
  // read straight from storage and must come out of reset as 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      buf_count_q   <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.ram_dout;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      // Simultaneous push and pop leave the count unchanged.
      buf_count_q <= buf_count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.ram_oe   = issue;
  assign bus.ram_addr = issue ? addr_q : ram_addr_q;  // hold last address when idle
  assign bus.ram_wr   = 1'b0;
  assign bus.ram_din  = '0;
  assign bus.m_valid  = (buf_count_q != 2'd0);
  assign bus.m_data   = buf_data_q[rd_ptr_q];
  assign bus.m_last   = buf_last_q[rd_ptr_q] && bus.m_valid;

  assign busy = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done = (state_q == S_FINISH);

endmodule
